cplx_acc_fifo: RTL and testbench
================================

// Module: cplx_acc_fifo
// PURPOSE
//  Downstream of the pipelined complex multiplier: integrates ACC_N successive complex products (in_vld strobes),
//  scales the sum by round-half-up arithmetic right shift, narrows to OUT_LEN, and buffers results in a FIFO with
//  valid/ready output. Converts the multiplier's no-backpressure stream into a decimated, flow-controlled stream.
// PARAMETERS
//  IN_LEN     16               width of in_re/in_im (= 2*DATA_LEN of the multiplier)
//  ACC_N      16               products per dump, >=1 (any integer, not only powers of 2)
//  SHIFT      $clog2(ACC_N)    right shift applied to the sum (0 = no shift, no rounding)
//  OUT_LEN    16               width of out_re/out_im
//  FIFO_DEPTH 4                output FIFO entries, power of 2, >=2
// PORTS
//  clk      in   1        clock
//  rst      in   1        reset, asynchronous, active-high
//  clr      in   1        synchronous clear of accumulation state (see BEHAVIOUR)
//  in_re    in   IN_LEN   signed product, real part
//  in_im    in   IN_LEN   signed product, imaginary part
//  in_vld   in   1        sample qualifier; sampled every cycle, no ready (source cannot stall)
//  out_re   out  OUT_LEN  signed result, real part (FIFO head)
//  out_im   out  OUT_LEN  signed result, imaginary part (FIFO head)
//  out_vld  out  1        FIFO non-empty
//  out_rdy  in   1        consumer accepts head when out_vld&&out_rdy
//  ovf      out  1        sticky: a result was dropped because the FIFO was full
//  sat      out  1        one-cycle pulse: the result written this cycle was clamped (re or im)
// BEHAVIOUR
//  Reset: all outputs 0; cnt=0, accumulators 0, stage-1 valid 0, FIFO empty. Async reset mid-frame discards everything.
//  ACC_W = IN_LEN+$clog2(ACC_N)+1; sign-extend inputs; internal sum never overflows.
//  Counter cnt 0..ACC_N-1, advances only on in_vld. cnt==0: acc<=in (load); else acc<=acc+in.
//  On in_vld with cnt==ACC_N-1: cnt<=0; stage-1 reg <= acc+in, s1_vld<=1 (ACC_N==1: every sample dumps).
//  Stage 2 (next edge): r = SHIFT>0 ? (s1 + 2**(SHIFT-1)) >>> SHIFT : s1; narrow to OUT_LEN; FIFO write.
//  Latency: last sample sampled at edge k -> FIFO write at edge k+1 -> out_vld=1 after edge k+1 (2 clocks).
//  Gaps in in_vld do not affect results; partial sums persist indefinitely.
//  FIFO: first-word fall-through; out_re/out_im valid while out_vld; pop on out_vld&&out_rdy.
//  Full and write pending: if a pop occurs in the same cycle, the write proceeds; otherwise the result is dropped, ovf<=1.
//  Empty: out_rdy ignored; out_re/out_im hold their last value.
//  ovf is cleared only by rst or clr.
//  clr: cnt<=0, acc<=0, s1_vld<=0, ovf<=0; FIFO contents are preserved. clr with in_vld: clr wins, sample discarded.
//  clr with a stage-2 write in the same cycle: the write completes (it was already in stage 1 before clr).
// CONFIGURATION
//  CPLX_ACC_SAT_EN defined: narrowing clamps to [-2**(OUT_LEN-1), 2**(OUT_LEN-1)-1] per component; sat pulses with the write.
//  Not defined: narrowing takes the low OUT_LEN bits (two's-complement wrap); sat tied 0; no clamp logic.
// STRUCTURE
//  Package cplx_dsp_pkg: cplx_t struct template widths, functions round_shr(value,shift) and sat_narrow(value).
//  Package cplx_dsp_pkg: localparam helpers for ACC_W.
//  Sub-module cplx_out_fifo: parameterised sync FWFT FIFO (width 2*OUT_LEN, FIFO_DEPTH) exposing full/empty.
//  Top level keeps the counter, accumulators, stage-1 register, and round/narrow logic.
// TESTING
//  1 ACC_N=4,SHIFT=2: re=1,2,3,4 im=-1,-2,-3,-4 contiguous -> out 3,-2, out_vld exactly 2 clocks after 4th sample.
//  2 Same data with in_vld every other cycle -> identical result; out_vld 2 clocks after last sample.
//  3 Defaults, out_rdy=0, 5 frames -> 4 entries, 5th dropped, ovf=1; then out_rdy=1 -> 4 results in order, ovf stays 1.
//  4 IN_LEN=OUT_LEN=16,ACC_N=2,SHIFT=0, SAT_EN: 30000+30000 -> 32767,sat=1; -30000 twice -> -32768. No macro -> -5536,sat=0.
//  5 ACC_N=4: 2 samples of 100, then clr together with in_vld=100, then four samples of 8 -> single result 8, ovf=0.
//  6 FIFO holding 2 entries, rst pulsed mid-frame -> out_vld/ovf/sat/out_* =0 same cycle; next full frame outputs correctly.

Source files
------------

// File: rtl/cplx_dsp_pkg.sv
// Shared types and arithmetic helpers for the complex accumulate/decimate path.
// Helpers work on a wide signed carrier; callers narrow the result with a size cast.
package cplx_dsp_pkg;

    localparam int CPLX_W = 16;
    localparam int WIDE_W = 64;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Width that holds ACC_N worst-case products plus a guard bit for rounding.
    function automatic int acc_width(input int in_len, input int acc_n);
        return in_len + $clog2(acc_n) + 1;
    endfunction

    function automatic logic signed [WIDE_W-1:0] round_shr(
        input logic signed [WIDE_W-1:0] value,
        input int                       shift
    );
        logic signed [WIDE_W-1:0] res;
        res = value;
        if (shift > 0)
            res = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        return res;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_narrow(
        input  logic signed [WIDE_W-1:0] value,
        input  int                       out_len,
        output logic                     clamped
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] res;
        hi      = (64'sd1 <<< (out_len - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_len - 1));
        res     = value;
        clamped = 1'b0;
        if (value > hi) begin
            res     = hi;
            clamped = 1'b1;
        end else if (value < lo) begin
            res     = lo;
            clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_out_fifo.sv
// Synchronous first-word-fall-through FIFO; when empty the output holds the last word popped.
// Caller is responsible for not writing while full unless a pop happens in the same cycle.
module cplx_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] last_reg;
    logic             do_rd;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            last_reg   <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                last_reg   <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    assign rd_data = empty ? last_reg : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/cplx_acc_fifo.sv
// Integrate-and-dump of ACC_N complex products, round-half-up shift, narrow, FIFO out.
// Define CPLX_ACC_SAT_EN to clamp on narrowing (and pulse sat); otherwise results wrap.
module cplx_acc_fifo
    import cplx_dsp_pkg::*;
#(
    parameter int IN_LEN     = 16,
    parameter int ACC_N      = 16,
    parameter int SHIFT      = $clog2(ACC_N),
    parameter int OUT_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic signed [IN_LEN-1:0]  in_re,
    input  logic signed [IN_LEN-1:0]  in_im,
    input  logic                      in_vld,
    output logic signed [OUT_LEN-1:0] out_re,
    output logic signed [OUT_LEN-1:0] out_im,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      ovf,
    output logic                      sat
);
    localparam int ACC_W = acc_width(IN_LEN, ACC_N);
    localparam int CNT_W = (ACC_N > 1) ? $clog2(ACC_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_N - 1);

    logic [CNT_W-1:0]          cnt_reg;
    logic                      s1_vld_reg;
    logic                      ovf_reg;
    logic                      last_smp;
    logic signed [IN_LEN-1:0]  in_c     [2];
    logic signed [OUT_LEN-1:0] narrow_c [2];
    logic [1:0]                clamp_c;
    logic [2*OUT_LEN-1:0]      fifo_rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic                      drop;

    assign in_c[0]  = in_re;
    assign in_c[1]  = in_im;
    assign last_smp = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            s1_vld_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg    <= '0;
            s1_vld_reg <= 1'b0;
        end else begin
            s1_vld_reg <= in_vld && last_smp;
            if (in_vld)
                cnt_reg <= last_smp ? '0 : cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        logic signed [ACC_W-1:0]   in_ext;
        logic signed [ACC_W-1:0]   sum;
        logic signed [ACC_W-1:0]   acc_reg;
        logic signed [ACC_W-1:0]   s1_reg;
        logic signed [OUT_LEN-1:0] narrow;
        logic                      clamp;

        assign in_ext = ACC_W'(in_c[gi]);
        // First sample of a frame loads rather than adds, so no explicit dump-clear is needed.
        assign sum    = (cnt_reg == '0) ? in_ext : acc_reg + in_ext;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_reg <= '0;
                s1_reg  <= '0;
            end else if (clr) begin
                acc_reg <= '0;
            end else if (in_vld) begin
                acc_reg <= sum;
                if (last_smp)
                    s1_reg <= sum;
            end
        end

`ifdef CPLX_ACC_SAT_EN
        always_comb begin
            clamp  = 1'b0;
            narrow = OUT_LEN'(sat_narrow(round_shr(WIDE_W'(s1_reg), SHIFT), OUT_LEN, clamp));
        end
`else
        assign clamp  = 1'b0;
        assign narrow = OUT_LEN'(round_shr(WIDE_W'(s1_reg), SHIFT));
`endif

        assign narrow_c[gi] = narrow;
        assign clamp_c[gi]  = clamp;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign fifo_rd = out_rdy && !fifo_empty;
    assign fifo_wr = s1_vld_reg && (!fifo_full || fifo_rd);
    assign drop    = s1_vld_reg && fifo_full && !fifo_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_reg <= 1'b0;
        else if (clr)
            ovf_reg <= 1'b0;
        else if (drop)
            ovf_reg <= 1'b1;
    end

    cplx_out_fifo #(
        .WIDTH (2 * OUT_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({narrow_c[0], narrow_c[1]}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_re  = fifo_rd_data[2*OUT_LEN-1:OUT_LEN];
    assign out_im  = fifo_rd_data[OUT_LEN-1:0];
    assign out_vld = !fifo_empty;
    assign ovf     = ovf_reg;
    assign sat     = fifo_wr && (|clamp_c);

endmodule

// File: tb/tb_cplx_acc_fifo.sv
// Scoreboard bench for cplx_acc_fifo: two lanes (ACC_N=4/SHIFT=2 and ACC_N=2/SHIFT=0),
// each with a queue-based reference model and a negedge monitor. Honours CPLX_ACC_SAT_EN.
module tb_cplx_acc_fifo;

`ifdef CPLX_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    typedef struct {
        longint re;
        longint im;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint div_floor(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0))
            q = q - 1;
        return q;
    endfunction

    // sum / 2**sh rounded half up
    function automatic longint scale(input longint s, input int sh);
        longint p;
        if (sh == 0)
            return s;
        p = longint'(1) << sh;
        return div_floor(s + p / 2, p);
    endfunction

    function automatic longint narrow16(input longint v, output bit clamped);
        longint w;
        clamped = 1'b0;
        if (SAT_EN) begin
            w = v;
            if (v > 32767) begin
                w = 32767;
                clamped = 1'b1;
            end else if (v < -32768) begin
                w = -32768;
                clamped = 1'b1;
            end
        end else begin
            w = v % 65536;
            if (w >= 32768)
                w = w - 65536;
            if (w < -32768)
                w = w + 65536;
        end
        return w;
    endfunction

    function automatic exp_t make_result(input longint s_re, input longint s_im, input int sh);
        exp_t r;
        bit   c0;
        bit   c1;
        r.re  = narrow16(scale(s_re, sh), c0);
        r.im  = narrow16(scale(s_im, sh), c1);
        r.sat = c0 | c1;
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : lane
        localparam int L_ACC_N = (gi == 0) ? 4 : 2;
        localparam int L_SHIFT = (gi == 0) ? 2 : 0;

        logic               rst_l;
        logic               clr_l;
        logic               in_vld_l;
        logic               out_rdy_l;
        logic signed [15:0] in_re_l;
        logic signed [15:0] in_im_l;
        logic signed [15:0] out_re_l;
        logic signed [15:0] out_im_l;
        logic               out_vld_l;
        logic               ovf_l;
        logic               sat_l;
        logic               done_l = 1'b0;

        cplx_acc_fifo #(
            .IN_LEN     (16),
            .ACC_N      (L_ACC_N),
            .SHIFT      (L_SHIFT),
            .OUT_LEN    (16),
            .FIFO_DEPTH (DEPTH)
        ) dut (
            .clk     (clk),
            .rst     (rst_l),
            .clr     (clr_l),
            .in_re   (in_re_l),
            .in_im   (in_im_l),
            .in_vld  (in_vld_l),
            .out_re  (out_re_l),
            .out_im  (out_im_l),
            .out_vld (out_vld_l),
            .out_rdy (out_rdy_l),
            .ovf     (ovf_l),
            .sat     (sat_l)
        );

        // Reference model state
        exp_t   exp_q[$];
        exp_t   pend;
        bit     pend_vld;
        bit     ovf_m;
        longint sum_re;
        longint sum_im;
        longint last_re;
        longint last_im;
        int     n_acc;

        always @(posedge clk or posedge rst_l) begin
            if (rst_l) begin
                exp_q.delete();
                pend_vld = 1'b0;
                ovf_m    = 1'b0;
                sum_re   = 0;
                sum_im   = 0;
                last_re  = 0;
                last_im  = 0;
                n_acc    = 0;
            end else begin
                if (pend_vld) begin
                    if (exp_q.size() < DEPTH)
                        exp_q.push_back(pend);
                    else
                        ovf_m = 1'b1;
                end
                if (clr_l) begin
                    n_acc    = 0;
                    sum_re   = 0;
                    sum_im   = 0;
                    pend_vld = 1'b0;
                    ovf_m    = 1'b0;
                end else if (in_vld_l) begin
                    sum_re = sum_re + in_re_l;
                    sum_im = sum_im + in_im_l;
                    n_acc++;
                    pend_vld = 1'b0;
                    if (n_acc == L_ACC_N) begin
                        pend     = make_result(sum_re, sum_im, L_SHIFT);
                        pend_vld = 1'b1;
                        n_acc    = 0;
                        sum_re   = 0;
                        sum_im   = 0;
                    end
                end else begin
                    pend_vld = 1'b0;
                end
            end
        end

        // Monitor: compares DUT outputs with the model, pops on accepted handshakes.
        always @(negedge clk) begin
            if (!rst_l) begin
                chk($sformatf("L%0d out_vld", gi), out_vld_l, exp_q.size() != 0);
                chk($sformatf("L%0d ovf", gi), ovf_l, ovf_m);
                chk($sformatf("L%0d sat", gi), sat_l,
                    pend_vld && pend.sat && ((exp_q.size() < DEPTH) || out_rdy_l));
                if (exp_q.size() == 0) begin
                    chk($sformatf("L%0d hold_re", gi), out_re_l, last_re);
                    chk($sformatf("L%0d hold_im", gi), out_im_l, last_im);
                end else begin
                    chk($sformatf("L%0d out_re", gi), out_re_l, exp_q[0].re);
                    chk($sformatf("L%0d out_im", gi), out_im_l, exp_q[0].im);
                    if (out_rdy_l) begin
                        last_re = exp_q[0].re;
                        last_im = exp_q[0].im;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end

        task automatic step(input bit v, input longint re, input longint im);
            in_vld_l = v;
            in_re_l  = 16'(re);
            in_im_l  = 16'(im);
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++)
                step(1'b0, 0, 0);
        endtask

        task automatic rand_frames(input int n_smp);
            for (int i = 0; i < n_smp; i++)
                step(1'b1, longint'(int'($urandom_range(0, 65535)) - 32768),
                           longint'(int'($urandom_range(0, 65535)) - 32768));
        endtask

        task automatic start_reset();
            rst_l     = 1'b1;
            clr_l     = 1'b0;
            in_vld_l  = 1'b0;
            in_re_l   = '0;
            in_im_l   = '0;
            out_rdy_l = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("L%0d rst out_vld", gi), out_vld_l, 0);
            chk($sformatf("L%0d rst ovf", gi), ovf_l, 0);
            chk($sformatf("L%0d rst sat", gi), sat_l, 0);
            chk($sformatf("L%0d rst out_re", gi), out_re_l, 0);
            chk($sformatf("L%0d rst out_im", gi), out_im_l, 0);
            rst_l = 1'b0;
        endtask

        task automatic rand_phase(input int n);
            for (int i = 0; i < n; i++) begin
                clr_l     = ($urandom_range(0, 39) == 0);
                out_rdy_l = ($urandom_range(0, 9) < 6);
                step($urandom_range(0, 9) < 7,
                     longint'(int'($urandom_range(0, 65535)) - 32768),
                     longint'(int'($urandom_range(0, 65535)) - 32768));
            end
            clr_l     = 1'b0;
            out_rdy_l = 1'b1;
            idle(12);
        endtask

        if (gi == 0) begin : g_stim
            initial begin
                start_reset();
                idle(2);
                // contiguous frame, then two-clock latency
                for (int i = 1; i <= 4; i++)
                    step(1'b1, i, -i);
                chk("T1 out_vld early", out_vld_l, 0);
                idle(1);
                chk("T1 out_vld", out_vld_l, 1);
                chk("T1 out_re", out_re_l, 3);
                chk("T1 out_im", out_im_l, -2);
                idle(3);
                // same frame with gaps
                for (int i = 1; i <= 4; i++) begin
                    step(1'b1, i, -i);
                    if (i < 4)
                        idle(1);
                end
                chk("T2 out_vld early", out_vld_l, 0);
                idle(1);
                chk("T2 out_vld", out_vld_l, 1);
                chk("T2 out_re", out_re_l, 3);
                chk("T2 out_im", out_im_l, -2);
                idle(3);
                // overflow: five frames into a four-entry FIFO
                out_rdy_l = 1'b0;
                rand_frames(20);
                idle(2);
                chk("T3 ovf", ovf_l, 1);
                chk("T3 out_vld", out_vld_l, 1);
                out_rdy_l = 1'b1;
                idle(6);
                chk("T3 ovf sticky", ovf_l, 1);
                chk("T3 drained", out_vld_l, 0);
                // async reset with two entries queued and a partial frame
                out_rdy_l = 1'b0;
                rand_frames(8);
                idle(2);
                chk("T6 pre out_vld", out_vld_l, 1);
                rand_frames(2);
                in_vld_l = 1'b0;
                #1 rst_l = 1'b1;
                #1;
                chk("T6 out_vld", out_vld_l, 0);
                chk("T6 ovf", ovf_l, 0);
                chk("T6 sat", sat_l, 0);
                chk("T6 out_re", out_re_l, 0);
                chk("T6 out_im", out_im_l, 0);
                @(posedge clk);
                #1;
                rst_l     = 1'b0;
                out_rdy_l = 1'b1;
                for (int i = 5; i <= 8; i++)
                    step(1'b1, i, -i);
                idle(1);
                chk("T6 post out_re", out_re_l, 7);
                chk("T6 post out_im", out_im_l, -6);
                idle(3);
                // clr discards partial sum and the coincident sample, clears ovf
                out_rdy_l = 1'b0;
                rand_frames(20);
                idle(2);
                out_rdy_l = 1'b1;
                idle(6);
                step(1'b1, 100, -100);
                step(1'b1, 100, -100);
                clr_l = 1'b1;
                step(1'b1, 100, -100);
                clr_l = 1'b0;
                chk("T5 ovf cleared", ovf_l, 0);
                for (int i = 0; i < 4; i++)
                    step(1'b1, 8, -8);
                idle(1);
                chk("T5 out_re", out_re_l, 8);
                chk("T5 out_im", out_im_l, -8);
                idle(1);
                chk("T5 single", out_vld_l, 0);
                rand_phase(400);
                done_l = 1'b1;
            end
        end else begin : g_stim
            initial begin
                start_reset();
                idle(2);
                // narrowing at the positive and negative limits
                step(1'b1, 30000, -30000);
                step(1'b1, 30000, -30000);
                chk("T4a sat", sat_l, SAT_EN);
                idle(1);
                chk("T4a out_re", out_re_l, SAT_EN ? 32767 : -5536);
                chk("T4a out_im", out_im_l, SAT_EN ? -32768 : 5536);
                chk("T4a sat end", sat_l, 0);
                step(1'b1, -30000, 30000);
                step(1'b1, -30000, 30000);
                chk("T4b sat", sat_l, SAT_EN);
                idle(1);
                chk("T4b out_re", out_re_l, SAT_EN ? -32768 : 5536);
                chk("T4b out_im", out_im_l, SAT_EN ? 32767 : -5536);
                idle(2);
                rand_phase(400);
                done_l = 1'b1;
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(lane[0].done_l && lane[1].done_l) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(lane[0].done_l && lane[1].done_l)) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles, expected lanes done", cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
